// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Lets NUM_REQ byte producers share one UART byte transmitter. Ownership is
// granted round-robin, one whole message at a time. A requester keeps the
// transmitter from its first accepted byte until it delivers a byte flagged
// last, or until it stalls for more than IDLE_MAX cycles. A one-byte holding
// register sits in front of the transmitter, so requester data only has to
// be valid in the cycle it is accepted.
//
// Handshake rule, used on both sides: a byte moves on a rising CLK edge
// exactly when valid and ready are both high in the cycle before that edge.
// Once a producer raises valid, it keeps valid and data stable until the
// byte is taken. Ready may depend combinationally on the consumer.
//
// Ports
//   CLK, RSTN    clock; asynchronous active-low reset
//   req_data     byte i sits at [8i+7:8i]
//   req_valid    requester i offers a byte
//   req_last     the offered byte ends requester i's message
//   req_ready    byte i is accepted this cycle when req_valid[i] is high
//   tx_data      holding register contents, to the transmitter's in
//   tx_valid     holding register full, to the transmitter's valid
//   tx_ready     from the transmitter's ready
//   grant        one-hot current owner, 0 when unowned
//   busy         a lock is held or the holding register is full
//   o_dbg_state  FSM state (0 = IDLE, 1 = LOCKED)
module uart_tx_arbiter #(
    parameter int                    NUM_REQ    = 2,
    parameter int                    IDLE_WIDTH = 12,
    parameter logic [IDLE_WIDTH-1:0] IDLE_MAX   = 12'd4095
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   o_dbg_state
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    logic [OW-1:0]         r_owner;
    logic [OW-1:0]         r_rr_last;
    logic [IDLE_WIDTH-1:0] r_idle_cnt;
    logic [7:0]            r_hold_data;
    logic                  r_hold_full;

    logic                  w_locked;
    logic                  w_can_take;
    logic                  w_accept;
    logic                  w_any;
    logic [OW-1:0]         w_pick;
    logic [OW-1:0]         w_idx;
    logic                  w_found;
    logic                  w_owner_valid;
    logic                  w_owner_last;
    logic [7:0]            w_owner_data;

    assign w_locked   = (r_state == S_LOCKED);
    // The holding register can take a byte if it is empty or is draining now.
    assign w_can_take = !r_hold_full || tx_ready;
    assign w_accept   = w_locked && w_owner_valid && w_can_take;
    assign w_any      = |req_valid;

    // Cyclic search starting one past the last released owner; the first
    // hit wins, so the search wraps from NUM_REQ-1 back to 0.
    always_comb begin
        w_pick  = r_rr_last;
        w_idx   = r_rr_last;
        w_found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_idx = (w_idx == OW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            if (req_valid[w_idx] && !w_found) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Owner-side multiplexers, plus grant and ready decode.
    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_last  = 1'b0;
        w_owner_data  = 8'h00;
        grant         = '0;
        req_ready     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == OW'(i)) begin
                w_owner_valid = req_valid[i];
                w_owner_last  = req_last[i];
                w_owner_data  = req_data[8*i +: 8];
            end
            grant[i]     = w_locked && (r_owner == OW'(i));
            req_ready[i] = grant[i] && w_can_take;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_last   <= OW'(NUM_REQ - 1);
            r_idle_cnt  <= '0;
            r_hold_data <= 8'h00;
            r_hold_full <= 1'b0;
        end else begin
            // Holding register: an accept always wins over a drain, which
            // leaves the register full with the new byte.
            if (w_accept) begin
                r_hold_data <= w_owner_data;
                r_hold_full <= 1'b1;
            end else if (r_hold_full && tx_ready) begin
                r_hold_full <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    // Arbitration may proceed while the previous message's
                    // last byte is still held; w_can_take protects it.
                    if (w_any) begin
                        r_owner    <= w_pick;
                        r_idle_cnt <= '0;
                        r_state    <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (w_accept) begin
                        r_idle_cnt <= '0;
                        if (w_owner_last) begin
                            r_state   <= S_IDLE;
                            r_rr_last <= r_owner;
                        end
                    end else if (!w_owner_valid) begin
                        // Abandoned message: drop the lock; a held byte is
                        // still sent.
                        if (r_idle_cnt == IDLE_MAX) begin
                            r_state    <= S_IDLE;
                            r_rr_last  <= r_owner;
                            r_idle_cnt <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_valid    = r_hold_full;
    assign tx_data     = r_hold_data;
    assign busy        = w_locked || r_hold_full;
    assign o_dbg_state = w_locked;

endmodule
